pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirect flushes and memory-busy freeze.
// Optional performance counters are compiled in when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  id_reg1,
  input  logic [2:0]  id_reg2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic        ex_valid,
  input  logic        ex_memRead,
  input  logic [2:0]  ex_regD,
  input  logic        ex_taken,
  input  logic [15:0] ex_jmpLoc,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_freeze,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  state_e      state_q, state_d, saved_q, saved_d, eff_state;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] pc_target_q;
  logic        target_ld;
  logic        hazard;

  assign hazard = ex_valid & ex_memRead &
                  ((id_use1 & (id_reg1 == ex_regD)) | (id_use2 & (id_reg2 == ex_regD)));

  // Leaving MEM_WAIT acts as the interrupted state in the same cycle.
  assign eff_state = (state_q == StMemWait) ? saved_q : state_q;

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    target_ld    = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    pc_load      = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_freeze    = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_freeze = 1'b1;
      state_d   = StMemWait;
      if (state_q != StMemWait) saved_d = state_q;
    end else begin
      case (eff_state)
        StFlush: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q <= 2'd1) begin
            state_d = StRun;
            cnt_d   = 2'd0;
          end else begin
            state_d = StFlush;
            cnt_d   = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = StRun;
          if (ex_taken) begin
            pc_load      = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            target_ld    = 1'b1;
            if (FETCH_LAT > 0) begin
              state_d = StFlush;
              cnt_d   = 2'(FETCH_LAT);
            end
          end else if (hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      saved_q     <= StRun;
      cnt_q       <= 2'd0;
      pc_target_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      if (target_ld) pc_target_q <= ex_jmpLoc;
    end
  end

  assign pc_target = pc_target_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] stall_q, flush_q;
  logic        stall_ev;

  assign stall_ev = mem_busy | (~ex_taken & hazard & (eff_state == StRun));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      if (stall_ev && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (if_id_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic,
// checked against a cycle-level model of remaining flush cycles and event counts.
module tb_pipe_hazard_ctrl;

  localparam int unsigned FetchLat = 2;

  typedef struct packed {
    logic        rst_n;
    logic [2:0]  reg1;
    logic [2:0]  reg2;
    logic        use1;
    logic        use2;
    logic        valid;
    logic        memrd;
    logic [2:0]  regd;
    logic        taken;
    logic [15:0] jmp;
    logic        busy;
  } stim_t;

  // ctl = {pc_en, pc_load, if_id_en, if_id_flush, id_ex_bubble, ex_freeze}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [15:0] tgt;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  id_reg1 = '0, id_reg2 = '0, ex_regD = '0;
  logic        id_use1 = 1'b0, id_use2 = 1'b0, ex_valid = 1'b0, ex_memRead = 1'b0;
  logic        ex_taken = 1'b0, mem_busy = 1'b0;
  logic [15:0] ex_jmpLoc = '0;
  logic        pc_en, pc_load, if_id_en, if_id_flush, id_ex_bubble, ex_freeze;
  logic [15:0] pc_target, stall_cnt, flush_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Model state: flush cycles still owed, last redirect target, event totals.
  int          m_left = 0;
  logic [15:0] m_tgt = '0;
  int          m_stall = 0;
  int          m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FETCH_LAT(FetchLat)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_regD(ex_regD),
    .ex_taken(ex_taken), .ex_jmpLoc(ex_jmpLoc), .mem_busy(mem_busy),
    .pc_en(pc_en), .pc_load(pc_load), .pc_target(pc_target),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_freeze(ex_freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t load_use();
    stim_t s;
    s = idle();
    s.valid = 1'b1;
    s.memrd = 1'b1;
    s.regd  = 3'd3;
    s.reg1  = 3'd3;
    s.use1  = 1'b1;
    return s;
  endfunction

  function automatic stim_t branch(input logic [15:0] tgt);
    stim_t s;
    s = idle();
    s.taken = 1'b1;
    s.jmp   = tgt;
    return s;
  endfunction

  function automatic stim_t busy();
    stim_t s;
    s = idle();
    s.busy = 1'b1;
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic run(input stim_t s);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    rst_n = s.rst_n; id_reg1 = s.reg1; id_reg2 = s.reg2; id_use1 = s.use1; id_use2 = s.use2;
    ex_valid = s.valid; ex_memRead = s.memrd; ex_regD = s.regd; ex_taken = s.taken;
    ex_jmpLoc = s.jmp; mem_busy = s.busy;
    if (!s.rst_n) begin
      m_left = 0; m_tgt = '0; m_stall = 0; m_flush = 0;
      e.ctl = 6'b000110; e.tgt = '0; e.stall = '0; e.flush = '0;
    end else begin
      e.tgt = m_tgt; e.stall = 16'(m_stall); e.flush = 16'(m_flush);
      hz = s.valid && s.memrd && ((s.use1 && s.reg1 == s.regd) || (s.use2 && s.reg2 == s.regd));
      if (s.busy) begin
        e.ctl = 6'b000001;
        m_stall = sat(m_stall);
      end else if (m_left > 0) begin
        e.ctl = 6'b101110;
        m_left--;
      end else if (s.taken) begin
        e.ctl = 6'b111110;
        m_left = int'(FetchLat);
        m_tgt = s.jmp;
      end else if (hz) begin
        e.ctl = 6'b000010;
        m_stall = sat(m_stall);
      end else begin
        e.ctl = 6'b101000;
      end
      if (e.ctl[2]) m_flush = sat(m_flush);
    end
`ifndef PIPE_HAZARD_CTRL_PERF_EN
    e.stall = '0;
    e.flush = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic run_n(input stim_t s, input int n);
    for (int i = 0; i < n; i++) run(s);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if ({pc_en, pc_load, if_id_en, if_id_flush, id_ex_bubble, ex_freeze} != mon_e.ctl) begin
        n_fail++;
        $display("FAIL ctl @%0t: got %b expected %b (pc_en,pc_load,if_id_en,flush,bubble,freeze)",
                 $time, {pc_en, pc_load, if_id_en, if_id_flush, id_ex_bubble, ex_freeze},
                 mon_e.ctl);
      end
      n_checks++;
      if (pc_target != mon_e.tgt) begin
        n_fail++;
        $display("FAIL pc_target @%0t: got %h expected %h", $time, pc_target, mon_e.tgt);
      end
      n_checks++;
      if (stall_cnt != mon_e.stall || flush_cnt != mon_e.flush) begin
        n_fail++;
        $display("FAIL counters @%0t: got stall=%h flush=%h expected stall=%h flush=%h",
                 $time, stall_cnt, flush_cnt, mon_e.stall, mon_e.flush);
      end
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    run_n(s, 3);
    run_n(idle(), 2);
    // Single load-use stall then defaults.
    run(load_use());
    run_n(idle(), 2);
    // Redirect with two fetch-latency flush cycles.
    run(branch(16'h0040));
    run_n(idle(), 4);
    // Freeze while the last flush cycle is pending.
    run(branch(16'h1234));
    run(idle());
    run_n(busy(), 3);
    run_n(idle(), 3);
    // Branch and load-use together: branch wins.
    s = load_use();
    s.taken = 1'b1;
    s.jmp = 16'hBEEF;
    run(s);
    run_n(load_use(), 3);
    run_n(idle(), 2);
    // Reset during the first flush cycle.
    run(branch(16'h0abc));
    s = branch(16'h5555);
    s.rst_n = 1'b0;
    run(s);
    run_n(idle(), 3);
    // Counter totals: five stalls plus two busy cycles.
    for (int i = 0; i < 5; i++) begin
      run(load_use());
      run(idle());
    end
    run_n(busy(), 2);
    run_n(idle(), 2);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    s = idle();
    s.rst_n = 1'b0;
    run(s);
    run_n(busy(), 65536);
    run(load_use());
    run_n(idle(), 2);
`endif
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = ($urandom_range(99) != 0);
      s.reg1  = 3'($urandom_range(7));
      s.reg2  = 3'($urandom_range(7));
      s.regd  = 3'($urandom_range(7));
      s.use1  = 1'($urandom_range(1));
      s.use2  = 1'($urandom_range(1));
      s.valid = ($urandom_range(3) != 0);
      s.memrd = 1'($urandom_range(1));
      s.taken = ($urandom_range(5) == 0);
      s.jmp   = 16'($urandom);
      s.busy  = ($urandom_range(7) == 0);
      run(s);
    end
    run_n(idle(), 2);
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
